mult_seq: RTL
=============

MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply; sampled only while idle.
REQ-005 The block SHALL have port a, input, WIDTH bits: unsigned multiplicand, captured on the accepted start edge.
REQ-006 The block SHALL have port b, input, WIDTH bits: unsigned multiplier, captured on the accepted start edge.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a multiply is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse on the edge that updates result.
REQ-009 The block SHALL have port result, output, 2*WIDTH bits: last completed product, held between completions.

Function
REQ-010 The block SHALL implement a two-state FSM, IDLE and RUN.
REQ-011 In IDLE, a clock edge with start=1 SHALL capture a and b, clear the internal accumulator, load the iteration counter, and move to RUN with busy=1.
REQ-012 In RUN, each edge SHALL add the shifted multiplicand to the accumulator when the current multiplier LSB is 1, then shift the multiplicand left by 1, shift the multiplier right by 1, and decrement the counter.
REQ-013 Without MULT_SEQ_EARLY_EXIT_EN, RUN SHALL last exactly WIDTH edges, so done=1 and result are valid exactly WIDTH cycles after the accepted start edge.
REQ-014 On the final RUN edge, the block SHALL write the complete product to result, pulse done=1 for one cycle, drop busy to 0, and return to IDLE.
REQ-015 The product SHALL be unsigned and exact in 2*WIDTH bits; overflow cannot occur and no flag is provided.
REQ-016 The block SHALL ignore start, a and b while busy=1; an in-flight operation is never disturbed.
REQ-017 The done cycle SHALL be an IDLE cycle, so start=1 in that cycle is accepted and gives back-to-back operation with no gap.
REQ-018 Operands of zero SHALL complete normally with result=0 and the same latency as any other operand.
REQ-019 When start=0, result SHALL hold its last value indefinitely, and done SHALL be 0 outside the completion cycle.

Reset
REQ-020 rst=1 on an edge SHALL force IDLE, busy=0, done=0, result=0, and clear the accumulator and counter.
REQ-021 Reset SHALL take priority over start and over any in-flight operation; an aborted operation SHALL never assert done.
REQ-022 A start that is high on the same edge as rst=1 SHALL be ignored.

Configuration
REQ-023 Macro MULT_SEQ_EARLY_EXIT_EN, when defined, SHALL make RUN end on the first edge at which the remaining (shifted) multiplier becomes zero, giving a latency of max(1, index of most-significant set bit of b + 1) cycles.
REQ-024 When MULT_SEQ_EARLY_EXIT_EN is defined, all other behaviour (result value, done pulse, busy, reset, back-to-back) SHALL be identical to the fixed-latency build.
REQ-025 When MULT_SEQ_EARLY_EXIT_EN is undefined, latency SHALL be fixed at WIDTH cycles for all operands.

Verification
REQ-026 The bench SHALL cover basic latency: WIDTH=8, a=3, b=3, start for one cycle -> done exactly 8 cycles later, result=9, busy high for those 8 cycles.
REQ-027 The bench SHALL cover the maximum product: WIDTH=8, a=255, b=255 -> result=65025 (0xFE01); WIDTH=3, a=7, b=7 -> result=49.
REQ-028 The bench SHALL cover start during busy: start 3*3, then in cycle 3 of RUN apply start with a=5, b=5 -> only result=9 and a single done pulse; the second request is ignored.
REQ-029 The bench SHALL cover reset mid-operation: start 200*100, then assert rst in RUN cycle 4 -> busy=0, done never asserted, result=0; a following 6*7 -> result=42.
REQ-030 The bench SHALL cover back-to-back: hold start=1 across the done cycle with new operands 12*11 -> second done exactly 8 cycles after the first, result=132; result=0 holds for a=0 or b=0.
REQ-031 The bench SHALL cover early exit (macro defined): b=1, a=200 -> done 1 cycle after start, result=200; b=0 -> 1 cycle, result=0; b=128 -> 8 cycles.

Source files
------------

// File: rtl/mult_seq.sv
// Sequential shift-and-add unsigned multiplier: one multiplier bit per clock.
// Optional `MULT_SEQ_EARLY_EXIT_EN ends the run once the remaining multiplier is zero.
module mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] result_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;

  logic [2*WIDTH-1:0] acc_d;
  logic               last_d;

  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef MULT_SEQ_EARLY_EXIT_EN
    // Stop as soon as no set bits remain after this edge's shift.
    last_d = (cnt_q == CW'(1)) || (mplier_q[WIDTH-1:1] == '0);
`else
    last_d = (cnt_q == CW'(1));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= CW'(WIDTH);
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          if (last_d) begin
            result_q <= acc_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
